pc_head_32_unit: RTL and testbench

//   Program-counter head register of the MIPS single-cycle datapath.
//   - Holds the address of the instruction currently being fetched.
//   - Each rising clock edge loads the next-PC value computed upstream
//     (PC+4, branch or jump target) and presents it to instruction

---
 rtl/pc_head_32_unit_if.sv | 18 +
 rtl/pc_head_32_unit.sv | 25 ++
 tb/tb_pc_head_32_unit.sv | 164 ++++++++++++++++
 3 files changed

// File: rtl/pc_head_32_unit_if.sv
// PC head bus: next-PC value into the register and current PC out of it.
// The master computes the next PC; the slave holds the current PC.
interface pc_head_32_unit_if #(
    parameter int WIDTH = 32
);
  logic [WIDTH-1:0] addr;
  logic [WIDTH-1:0] new_addr;

  modport master (
    output addr,
    input  new_addr
  );

  modport slave (
    input  addr,
    output new_addr
  );
endinterface

// File: rtl/pc_head_32_unit.sv
// Program-counter head register: loads the upstream next-PC every rising edge
// and drops to RESET_ADDR asynchronously while reset is low.
module pc_head_32_unit #(
    parameter int               WIDTH      = 32,
    parameter logic [WIDTH-1:0] RESET_ADDR = '0
) (
    input logic              clk,
    input logic              reset,
    pc_head_32_unit_if.slave pc_bus
);

  logic [WIDTH-1:0] pc_reg;

  // Plain copy of the next-PC value; alignment and arithmetic live upstream.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      pc_reg <= RESET_ADDR;
    end else begin
      pc_reg <= pc_bus.addr;
    end
  end

  assign pc_bus.new_addr = pc_reg;

endmodule

// File: tb/tb_pc_head_32_unit.sv
// Scoreboard bench for pc_head_32_unit: directed scenarios then random traffic.
module tb_pc_head_32_unit;

  localparam int          WIDTH      = 32;
  localparam logic [31:0] RESET_ADDR = 32'h0000_0000;

  logic clk;
  logic clk_en;
  logic reset;

  pc_head_32_unit_if #(.WIDTH(WIDTH)) pc_bus ();

  pc_head_32_unit #(
    .WIDTH     (WIDTH),
    .RESET_ADDR(RESET_ADDR)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .pc_bus(pc_bus)
  );

  // Gated clock so scenarios can hold clk low for arbitrary stretches.
  initial clk = 1'b0;
  always begin
    #5;
    if (clk_en) clk = ~clk;
    else        clk = 1'b0;
  end

  typedef struct {
    string       tag;
    logic [31:0] value;
  } exp_t;

  exp_t        exp_q[$];
  int          total;
  int          bad;
  logic [31:0] pc_model;

  // Monitor: pops each expectation and compares against the live output.
  initial begin
    exp_t e;
    forever begin
      wait (exp_q.size() != 0);
      e = exp_q.pop_front();
      total++;
      if (pc_bus.new_addr !== e.value) begin
        bad++;
        $display("FAIL %s: new_addr=%h required=%h", e.tag, pc_bus.new_addr, e.value);
      end else begin
        $display("ok   %s: new_addr=%h", e.tag, pc_bus.new_addr);
      end
    end
  end

  task automatic expect_pc(input string tag, input logic [31:0] value);
    exp_t e;
    e.tag   = tag;
    e.value = value;
    exp_q.push_back(e);
    for (int i = 0; i < 10 && exp_q.size() != 0; i++) #0;
    if (exp_q.size() != 0) begin
      total++;
      bad++;
      $display("FAIL %s: monitor did not consume expectation, required=%h", tag, value);
      exp_q.delete();
    end
  endtask

  // Rising edge with reset high loads addr; otherwise the reset value is kept.
  task automatic edge_and_model();
    @(posedge clk);
    pc_model = reset ? pc_bus.addr : RESET_ADDR;
    #1;
  endtask

  initial begin
    total       = 0;
    bad         = 0;
    clk_en      = 1'b0;
    reset       = 1'b1;
    pc_bus.addr = 32'h1;

    // Async reset with clk held low
    #3 reset = 1'b0;
    pc_model = RESET_ADDR;
    #1 expect_pc("async_reset", pc_model);

    // Release with no clock edge: value must hold
    reset = 1'b1;
    #1 expect_pc("release_instant", pc_model);
    #20 expect_pc("release_no_edge", pc_model);

    // First load and falling-edge hold
    pc_bus.addr = 32'h1;
    clk_en = 1'b1;
    edge_and_model();
    expect_pc("load_first", 32'h0000_0001);
    @(negedge clk); #1 expect_pc("falling_hold", 32'h0000_0001);

    // addr change between edges has no effect until the next rising edge
    pc_bus.addr = 32'h0000_FFFF;
    #1 expect_pc("addr_change_no_edge", 32'h0000_0001);
    edge_and_model();
    expect_pc("load_ffff", 32'h0000_FFFF);
    @(negedge clk) pc_bus.addr = 32'h1;
    edge_and_model();
    expect_pc("load_back_1", 32'h0000_0001);

    // Clock stopped for two periods while addr wiggles
    @(negedge clk) clk_en = 1'b0;
    pc_bus.addr = 32'h1234_5678;
    #20 expect_pc("clock_stopped", 32'h0000_0001);
    clk_en = 1'b1;

    // Reset held across a rising edge wins over the load
    @(negedge clk);
    reset       = 1'b0;
    pc_bus.addr = 32'hDEAD_BEEC;
    #1 expect_pc("midop_async_reset", RESET_ADDR);
    edge_and_model();
    expect_pc("reset_priority", RESET_ADDR);
    @(negedge clk) reset = 1'b1;
    edge_and_model();
    expect_pc("after_release_load", 32'hDEAD_BEEC);

    // Extremes: all-ones then zero, copied verbatim
    @(negedge clk) pc_bus.addr = 32'hFFFF_FFFF;
    edge_and_model();
    expect_pc("load_all_ones", 32'hFFFF_FFFF);
    @(negedge clk) pc_bus.addr = 32'h0000_0000;
    edge_and_model();
    expect_pc("load_zero", 32'h0000_0000);
    @(negedge clk) pc_bus.addr = 32'h0000_0003;
    edge_and_model();
    expect_pc("load_unaligned", 32'h0000_0003);

    // Random traffic with occasional async pulses and reset-across-edge cycles
    for (int n = 0; n < 200; n++) begin
      int sel;
      @(negedge clk);
      sel = $urandom_range(0, 11);
      reset = 1'b1;
      pc_bus.addr = $urandom;
      if (sel == 0) begin
        reset = 1'b0;
        pc_model = RESET_ADDR;
        #1 expect_pc("rnd_async_pulse", pc_model);
        #1 reset = 1'b1;
      end else if (sel == 1) begin
        reset = 1'b0;
        pc_model = RESET_ADDR;
      end
      #1 expect_pc("rnd_between_edges", pc_model);
      pc_bus.addr = $urandom;
      edge_and_model();
      expect_pc("rnd_edge", pc_model);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
